// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem fetch at a
// time, and presents fetched words to decode through the IF/ID register.
module if_stage #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]        INST_NOP = 32'h0000_0013,
  parameter int                 HOLD_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jmp_en_i,
  input  logic [ADDR_W-1:0] jmp_to_i,
  input  logic [HOLD_W-1:0] hold_code_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_inst_addr;
  logic              r_inst_valid;
  logic [31:0]       r_buf_inst;
  logic [ADDR_W-1:0] r_buf_addr;
  logic              r_buf_full;

  state_e            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [31:0]       w_inst_nxt;
  logic [ADDR_W-1:0] w_inst_addr_nxt;
  logic              w_inst_valid_nxt;
  logic              w_buf_load;
  logic              w_buf_full_nxt;
  logic              w_hold;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_jmp_tgt;

  assign w_hold    = |hold_code_i;
  assign w_pc_inc  = r_pc + ADDR_W'(4);
  assign w_jmp_tgt = jmp_to_i & ~ADDR_W'(3);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_buf_load       = 1'b0;
    w_buf_full_nxt   = r_buf_full;
    w_inst_nxt       = w_hold ? r_inst       : INST_NOP;
    w_inst_addr_nxt  = w_hold ? r_inst_addr  : r_pc;
    w_inst_valid_nxt = w_hold ? r_inst_valid : 1'b0;

    case (r_state)
      S_REQ: begin
        if (imem_gnt_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          w_pc_nxt = w_pc_inc;
          if (w_hold) begin
            w_buf_load     = 1'b1;
            w_buf_full_nxt = 1'b1;
            w_state_nxt    = S_FULL;
          end else begin
            w_inst_nxt       = imem_rdata_i;
            w_inst_addr_nxt  = r_pc;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = S_REQ;
          end
        end
      end
      S_FULL: begin
        if (!w_hold) begin
          w_inst_nxt       = r_buf_inst;
          w_inst_addr_nxt  = r_buf_addr;
          w_inst_valid_nxt = 1'b1;
          w_buf_full_nxt   = 1'b0;
          w_state_nxt      = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase

    // A redirect overrides hold and everything above; an in-flight grant or
    // response forces a pass through DROP so the stale word is swallowed.
    if (jmp_en_i) begin
      w_pc_nxt         = w_jmp_tgt;
      w_inst_nxt       = INST_NOP;
      w_inst_addr_nxt  = r_pc;
      w_inst_valid_nxt = 1'b0;
      w_buf_load       = 1'b0;
      w_buf_full_nxt   = 1'b0;
      case (r_state)
        S_REQ:   w_state_nxt = imem_gnt_i    ? S_DROP : S_REQ;
        S_WAIT:  w_state_nxt = imem_rvalid_i ? S_REQ  : S_DROP;
        S_DROP:  w_state_nxt = imem_rvalid_i ? S_REQ  : S_DROP;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_inst       <= INST_NOP;
      r_inst_addr  <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_buf_full   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_addr  <= w_inst_addr_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_buf_full   <= w_buf_full_nxt;
    end
  end

  // NOTE: skid-buffer payload is left unreset; r_buf_full qualifies it, so
  // the data flops need no reset network.
  always_ff @(posedge clk) begin
    if (w_buf_load) begin
      r_buf_inst <= imem_rdata_i;
      r_buf_addr <= r_pc;
    end
  end

  assign imem_req_o   = (r_state == S_REQ);
  assign imem_addr_o  = r_pc;
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_inst_addr;
  assign inst_valid_o = r_inst_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed cycle-by-cycle bench for if_stage: a table of per-cycle memory and
// control inputs with hand-computed post-edge outputs, plus a reset sequence.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jmp_en_i;
  logic [31:0] jmp_to_i;
  logic [2:0]  hold_code_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .jmp_en_i      (jmp_en_i),
    .jmp_to_i      (jmp_to_i),
    .hold_code_i   (hold_code_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [2:0]  hold;
    logic        jmp;
    logic [31:0] jto;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] iaddr;
    logic        val;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic [2:0] hold, input logic jmp, input logic [31:0] jto,
                     input logic req, input logic [31:0] addr, input logic [31:0] inst,
                     input logic [31:0] iaddr, input logic val);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.hold = hold; v.jmp = jmp; v.jto = jto;
    v.req = req; v.addr = addr; v.inst = inst; v.iaddr = iaddr; v.val = val;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic [2:0] hold, input logic jmp, input logic [31:0] jto);
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rdata;
    hold_code_i   = hold;
    jmp_en_i      = jmp;
    jmp_to_i      = jto;
  endtask

  task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] inst, input logic [31:0] iaddr, input logic val);
    check({tag, ".req"},   {31'd0, imem_req_o},   {31'd0, req});
    check({tag, ".addr"},  imem_addr_o,           addr);
    check({tag, ".inst"},  inst_o,                inst);
    check({tag, ".iaddr"}, inst_addr_o,           iaddr);
    check({tag, ".valid"}, {31'd0, inst_valid_o}, {31'd0, val});
  endtask

  initial begin
    //   gnt rv rdata          hold  jmp jto            req addr           inst           iaddr          val
    // zero-wait memory: 0, 4, 8 land in IF/ID on alternate edges
    add(1, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'h0000_0000, NOP,           32'h0000_0000, 0);
    add(0, 1, 32'hA5A5_0000,  3'd0, 0, 32'h0,          1, 32'h0000_0004, 32'hA5A5_0000, 32'h0000_0000, 1);
    add(1, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'h0000_0004, NOP,           32'h0000_0004, 0);
    add(0, 1, 32'hA5A5_0004,  3'd0, 0, 32'h0,          1, 32'h0000_0008, 32'hA5A5_0004, 32'h0000_0004, 1);
    add(1, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'h0000_0008, NOP,           32'h0000_0008, 0);
    add(0, 1, 32'hA5A5_0008,  3'd0, 0, 32'h0,          1, 32'h0000_000C, 32'hA5A5_0008, 32'h0000_0008, 1);
    // 2-cycle grant delay at 0xC, then one extra rvalid wait
    add(0, 0, 32'h0,          3'd0, 0, 32'h0,          1, 32'h0000_000C, NOP,           32'h0000_000C, 0);
    add(0, 0, 32'h0,          3'd0, 0, 32'h0,          1, 32'h0000_000C, NOP,           32'h0000_000C, 0);
    add(1, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'h0000_000C, NOP,           32'h0000_000C, 0);
    add(0, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'h0000_000C, NOP,           32'h0000_000C, 0);
    add(0, 1, 32'hA5A5_000C,  3'd0, 0, 32'h0,          1, 32'h0000_0010, 32'hA5A5_000C, 32'h0000_000C, 1);
    // 4-cycle hold: IF/ID frozen, 0x10 parked in buffer, stray rvalid ignored
    add(1, 0, 32'h0,          3'd2, 0, 32'h0,          0, 32'h0000_0010, 32'hA5A5_000C, 32'h0000_000C, 1);
    add(0, 1, 32'hA5A5_0010,  3'd2, 0, 32'h0,          0, 32'h0000_0014, 32'hA5A5_000C, 32'h0000_000C, 1);
    add(0, 0, 32'h0,          3'd2, 0, 32'h0,          0, 32'h0000_0014, 32'hA5A5_000C, 32'h0000_000C, 1);
    add(0, 1, 32'hDEAD_BEEF,  3'd2, 0, 32'h0,          0, 32'h0000_0014, 32'hA5A5_000C, 32'h0000_000C, 1);
    add(0, 0, 32'h0,          3'd0, 0, 32'h0,          1, 32'h0000_0014, 32'hA5A5_0010, 32'h0000_0010, 1);
    add(1, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'h0000_0014, NOP,           32'h0000_0014, 0);
    // jump in WAIT without rvalid -> DROP, stale word discarded, retarget 0x100
    add(0, 0, 32'h0,          3'd0, 1, 32'h0000_0103,  0, 32'h0000_0100, NOP,           32'h0000_0014, 0);
    add(0, 1, 32'hBAD0_BAD0,  3'd0, 0, 32'h0,          1, 32'h0000_0100, NOP,           32'h0000_0100, 0);
    add(1, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'h0000_0100, NOP,           32'h0000_0100, 0);
    add(0, 1, 32'hA5A5_0100,  3'd0, 0, 32'h0,          1, 32'h0000_0104, 32'hA5A5_0100, 32'h0000_0100, 1);
    // jump + hold + rvalid together: bubble wins, buffer stays empty
    add(1, 0, 32'h0,          3'd2, 0, 32'h0,          0, 32'h0000_0104, 32'hA5A5_0100, 32'h0000_0100, 1);
    add(0, 1, 32'hA5A5_0104,  3'd2, 1, 32'h0000_0200,  1, 32'h0000_0200, NOP,           32'h0000_0104, 0);
    add(0, 0, 32'h0,          3'd2, 0, 32'h0,          1, 32'h0000_0200, NOP,           32'h0000_0104, 0);
    // ungranted request retargeted to 0xFFFF_FFFC, then PC wraps to 0
    add(0, 0, 32'h0,          3'd0, 1, 32'hFFFF_FFFE,  1, 32'hFFFF_FFFC, NOP,           32'h0000_0200, 0);
    add(1, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'hFFFF_FFFC, NOP,           32'hFFFF_FFFC, 0);
    add(0, 1, 32'h5A5A_FFFC,  3'd0, 0, 32'h0,          1, 32'h0000_0000, 32'h5A5A_FFFC, 32'hFFFF_FFFC, 1);
    // jump in a granted REQ cycle -> DROP until the stale rvalid
    add(1, 0, 32'h0,          3'd0, 1, 32'h0000_0040,  0, 32'h0000_0040, NOP,           32'h0000_0000, 0);
    add(0, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'h0000_0040, NOP,           32'h0000_0040, 0);
    add(0, 1, 32'h1234_5678,  3'd0, 0, 32'h0,          1, 32'h0000_0040, NOP,           32'h0000_0040, 0);
    // jump while FULL clears the buffer without draining it
    add(1, 0, 32'h0,          3'd2, 0, 32'h0,          0, 32'h0000_0040, NOP,           32'h0000_0040, 0);
    add(0, 1, 32'hA5A5_0040,  3'd2, 0, 32'h0,          0, 32'h0000_0044, NOP,           32'h0000_0040, 0);
    add(0, 0, 32'h0,          3'd2, 1, 32'h0000_0080,  1, 32'h0000_0080, NOP,           32'h0000_0044, 0);
    add(0, 0, 32'h0,          3'd0, 0, 32'h0,          1, 32'h0000_0080, NOP,           32'h0000_0080, 0);
    // back-to-back jumps: WAIT -> DROP, then DROP with rvalid -> REQ
    add(1, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'h0000_0080, NOP,           32'h0000_0080, 0);
    add(0, 0, 32'h0,          3'd0, 1, 32'h0000_00C0,  0, 32'h0000_00C0, NOP,           32'h0000_0080, 0);
    add(0, 1, 32'hBAD0_0001,  3'd0, 1, 32'h0000_1004,  1, 32'h0000_1004, NOP,           32'h0000_00C0, 0);
    add(1, 0, 32'h0,          3'd0, 0, 32'h0,          0, 32'h0000_1004, NOP,           32'h0000_1004, 0);
    add(0, 1, 32'hA5A5_1004,  3'd0, 0, 32'h0,          1, 32'h0000_1008, 32'hA5A5_1004, 32'h0000_1004, 1);

    rst = 1'b1;
    drive(0, 0, 32'h0, 3'd0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].hold, vecs[i].jmp, vecs[i].jto);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].inst,
                vecs[i].iaddr, vecs[i].val);
    end

    // Reset asserted mid-fetch, then a clean fetch from RESET_PC.
    drive(1, 0, 32'h0, 3'd0, 0, 32'h0);
    @(posedge clk);
    #1;
    check_all("pre_rst", 1'b0, 32'h0000_1008, NOP, 32'h0000_1008, 1'b0);
    rst = 1'b1;
    drive(0, 1, 32'hCAFE_F00D, 3'd2, 1, 32'h0000_0300);
    @(posedge clk);
    #1;
    check_all("mid_rst", 1'b1, 32'h0, NOP, 32'h0, 1'b0);
    rst = 1'b0;
    drive(1, 0, 32'h0, 3'd0, 0, 32'h0);
    @(posedge clk);
    #1;
    check_all("post_rst_gnt", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    drive(0, 1, 32'hA5A5_0000, 3'd0, 0, 32'h0);
    @(posedge clk);
    #1;
    check_all("post_rst_data", 1'b1, 32'h4, 32'hA5A5_0000, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
